check_pass_default: RTL and testbench
=====================================

Name: check_pass_default

Overview:
- Password-check stage of the digital lock. Digits are base-3 values taken from the 2-bit `mod3_btn` bus, one digit per `enter` press.
- Collects a sequence of PASS_LEN digits. Depending on mode, it either programs a user password or compares the sequence against the user password or a built-in default password.
- Drives the unlock output `Q` and a 3-LED digit-progress display `led_4`.
- Sits between the debounced button front-end and the lock actuator/LED drivers.

Parameters:
- PASS_LEN, 3: digits per password, range 1..3. `led_4` shows up to 3 digits.
- DEF_PASS, 6'b10_01_10: default password, 2 bits per digit. Digit 0 is in bits [1:0] and is the first digit entered. Only the low 2*PASS_LEN bits are used.
- MAX_FAIL, 3: failed checks allowed before lockout. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_all  in  1  asynchronous, active-high reset of all state.
- mode  in  1  1 = program user password. Has priority over `mode_def`.
- mode_def  in  1  with `mode`=0: 1 = check against DEF_PASS, 0 = check against the user password.
- enter  in  1  digit-submit button, level signal, synchronous to `clk`.
- mod3_btn  in  2  digit value 0..2. Value 3 is invalid.
- lock_rst  in  1  synchronous relock; clears `Q` and the digit buffer.
- Q  out  1  1 = unlocked.
- led_4  out  3  thermometer count of digits entered so far.

Behaviour:
- Reset (`rst_all`=1, asynchronous):
  - `Q`=0, `led_4`=0.
  - Digit count = 0, digit buffer = 0.
  - User password register = DEF_PASS.
  - Fail counter = 0, `enter` edge register = 0.
- Enter detection:
  - `enter` is registered once; a press is `enter`=1 while the registered value is 0.
  - One digit is accepted per rising edge, one cycle after `enter` rises.
  - Holding `enter` high gives only one press.
- Digit acceptance: on a press with `mod3_btn`≠3, write the digit into buffer slot [count] and increment count.
- Invalid digit: a press with `mod3_btn`==3 is ignored. Count is unchanged and no LED changes.
- `led_4` encoding: count 0→000, 1→001, 2→011, 3→111. It updates the same cycle the count updates.
- When count reaches PASS_LEN (the accepting edge is the final digit):
  - `mode`=1: the user password register takes the buffer (including the final digit). `Q` is unchanged.
  - `mode`=0, `mode_def`=1: `Q`←1 if the full sequence equals DEF_PASS, else `Q`←0.
  - `mode`=0, `mode_def`=0: `Q`←1 if the full sequence equals the user password, else `Q`←0.
  - In all three cases, on the next cycle count and `led_4` return to 0 and the buffer clears.
- Mode sampling: `mode`/`mode_def` are sampled only on the completing press. Changing them mid-sequence does not clear the buffer.
- `lock_rst` (synchronous, higher priority than a press in the same cycle):
  - `Q`←0, count←0, buffer←0.
  - The user password and fail counter are kept.
- `rst_all` during a press wins: all state is cleared and the press is lost.
- `Q` holds its value between checks. A new complete check overwrites it.

Optional Feature:
- Macro `CHECK_PASS_LOCKOUT_EN`.
- When defined:
  - Each failed check increments a 2-bit saturating fail counter. A successful check clears it.
  - When the counter equals MAX_FAIL, all presses are ignored and `led_4` is forced to 3'b101 (lockout pattern).
  - Only `rst_all` exits lockout; `lock_rst` does not.
- When undefined: no fail counter, unlimited attempts.

Decomposition:
- Package `check_pass_pkg`:
  - Digit width constant (2).
  - Invalid-digit constant (2'd3).
  - Lockout LED pattern (3'b101).
  - Mode enum: PROG / CHK_DEF / CHK_USER.
- One natural sub-module, `enter_edge_det`: register plus rising-edge pulse generator for `enter`.
- Comparison, buffer and counter logic stay in the top module.

Test Plan:
- Reset: assert `rst_all` mid-operation with count=2 → `Q`=0, `led_4`=000 immediately, without waiting for a clock edge.
- Default check, correct: `mode`=0, `mode_def`=1, press 2,1,2 (DEF_PASS) → `led_4` goes 001, then 011, then 111. `Q`=1 after the third press, and `led_4` returns to 000 one cycle later.
- Default check, wrong: press 2,2,2 → `Q`=0. Then `lock_rst` after a correct unlock → `Q`=0 and count=0.
- Program and check: `mode`=1, press 1,0,1 → `Q` unchanged. Then `mode`=0, `mode_def`=0, press 1,0,1 → `Q`=1. Pressing 2,1,2 in the same mode → `Q`=0.
- Edge and invalid: hold `enter` high for 5 cycles → only 1 digit accepted. A press with `mod3_btn`=3 → count unchanged.
- Lockout (with `CHECK_PASS_LOCKOUT_EN`): 3 wrong checks → `led_4`=101 and further presses are ignored. `lock_rst` does not exit lockout; `rst_all` clears it.

Source files
------------

// File: rtl/check_pass_pkg.sv
// Shared constants, mode decode and LED helper for the password-check stage.
package check_pass_pkg;

    localparam int         DIGIT_W       = 2;
    localparam logic [1:0] DIGIT_INVALID = 2'd3;
    localparam logic [2:0] LED_LOCKOUT   = 3'b101;

    typedef enum logic [1:0] {
        PROG,
        CHK_DEF,
        CHK_USER
    } mode_e;

    function automatic mode_e decode_mode(input logic mode, input logic mode_def);
        mode_e m;
        if (mode)
            m = PROG;
        else if (mode_def)
            m = CHK_DEF;
        else
            m = CHK_USER;
        return m;
    endfunction

    function automatic logic [2:0] therm(input logic [1:0] n);
        logic [2:0] t;
        case (n)
            2'd0:    t = 3'b000;
            2'd1:    t = 3'b001;
            2'd2:    t = 3'b011;
            default: t = 3'b111;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/enter_edge_det.sv
// Registers the enter button and emits a one-cycle pulse on its rising edge.
module enter_edge_det (
    input  logic clk,
    input  logic rst_all,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level;

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all)
            r_level <= 1'b0;
        else
            r_level <= i_level;
    end

    assign o_pulse = i_level & ~r_level;

endmodule

// File: rtl/check_pass_default.sv
// Password-check stage: collects base-3 digits, programs or checks a password, drives Q/led_4.
// Optional lockout after repeated failed checks: define CHECK_PASS_LOCKOUT_EN.
module check_pass_default
    import check_pass_pkg::*;
#(
    parameter int         PASS_LEN = 3,
    parameter logic [5:0] DEF_PASS = 6'b10_01_10,
    parameter int         MAX_FAIL = 3
) (
    input  logic       clk,
    input  logic       rst_all,
    input  logic       mode,
    input  logic       mode_def,
    input  logic       enter,
    input  logic [1:0] mod3_btn,
    input  logic       lock_rst,
    output logic       Q,
    output logic [2:0] led_4
);

    localparam int                BUF_W    = DIGIT_W * PASS_LEN;
    localparam logic [1:0]        CNT_FULL = 2'(PASS_LEN);
    localparam logic [BUF_W-1:0]  DEF_CODE = DEF_PASS[BUF_W-1:0];

    if (PASS_LEN < 1 || PASS_LEN > 3 || MAX_FAIL < 1 || MAX_FAIL > 3) begin : g_param_check
        $error("check_pass_default: PASS_LEN and MAX_FAIL must be in 1..3");
    end

    logic             w_press;
    logic             w_accept;
    logic             w_last;
    logic             w_locked;
    logic             w_check_ok;
    mode_e            w_mode;
    logic [BUF_W-1:0] w_seq;

    logic [1:0]       r_count;
    logic [BUF_W-1:0] r_buf;
    logic [BUF_W-1:0] r_user_pw;
    logic             r_q;

    enter_edge_det u_enter_edge (
        .clk     (clk),
        .rst_all (rst_all),
        .i_level (enter),
        .o_pulse (w_press)
    );

    // Sequence as it stands once the pending digit lands in slot [count].
    for (genvar gi = 0; gi < PASS_LEN; gi++) begin : g_slot
        assign w_seq[gi*DIGIT_W +: DIGIT_W] = (r_count == 2'(gi)) ? mod3_btn
                                                                   : r_buf[gi*DIGIT_W +: DIGIT_W];
    end

    assign w_mode     = decode_mode(mode, mode_def);
    assign w_check_ok = (w_mode == CHK_DEF) ? (w_seq == DEF_CODE) : (w_seq == r_user_pw);
    assign w_last     = (r_count == CNT_FULL - 2'd1);
    assign w_accept   = w_press && (mod3_btn != DIGIT_INVALID) && !w_locked
                        && (r_count != CNT_FULL);

`ifdef CHECK_PASS_LOCKOUT_EN
    logic [1:0] r_fail;

    assign w_locked = (r_fail == 2'(MAX_FAIL));

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            r_fail <= 2'd0;
        end else if (!lock_rst && w_accept && w_last && (w_mode != PROG)) begin
            if (w_check_ok)
                r_fail <= 2'd0;
            else if (r_fail != 2'd3)
                r_fail <= r_fail + 2'd1;
        end
    end
`else
    assign w_locked = 1'b0;
`endif

    // A full buffer lingers for exactly one cycle so the third LED is visible.
    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            r_count   <= 2'd0;
            r_buf     <= '0;
            r_user_pw <= DEF_CODE;
            r_q       <= 1'b0;
        end else if (lock_rst) begin
            r_count <= 2'd0;
            r_buf   <= '0;
            r_q     <= 1'b0;
        end else if (r_count == CNT_FULL) begin
            r_count <= 2'd0;
            r_buf   <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 2'd1;
            r_buf   <= w_seq;
            if (w_last) begin
                if (w_mode == PROG)
                    r_user_pw <= w_seq;
                else
                    r_q <= w_check_ok;
            end
        end
    end

    assign Q     = r_q;
    assign led_4 = w_locked ? LED_LOCKOUT : therm(r_count);

endmodule

// File: tb/tb_check_pass_default.sv
// Scoreboard bench for check_pass_default: directed test-plan steps plus random presses.
module tb_check_pass_default;

    logic       clk = 1'b0;
    logic       rst_all;
    logic       mode;
    logic       mode_def;
    logic       enter;
    logic [1:0] mod3_btn;
    logic       lock_rst;
    logic       Q;
    logic [2:0] led_4;

    check_pass_default dut (
        .clk      (clk),
        .rst_all  (rst_all),
        .mode     (mode),
        .mode_def (mode_def),
        .enter    (enter),
        .mod3_btn (mod3_btn),
        .lock_rst (lock_rst),
        .Q        (Q),
        .led_4    (led_4)
    );

    always #5 clk = ~clk;

`ifdef CHECK_PASS_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif
    localparam int PL = 3;

    typedef struct {
        int         tag;
        logic [2:0] led;
        logic       q;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   pcyc   = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: list of digits entered, user password, Q, fail count.
    int digs[$];
    int upw[PL];
    int defpw[PL] = '{2, 1, 2};
    bit mq;
    int fails;

    always @(posedge clk) pcyc++;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tag <= pcyc) begin
            e = sb.pop_front();
            checks++;
            if (e.tag != pcyc || led_4 !== e.led || Q !== e.q) begin
                errors++;
                $display("FAIL %s cyc=%0d/%0d: led_4=%b Q=%b expected led_4=%b Q=%b",
                         e.name, pcyc, e.tag, led_4, Q, e.led, e.q);
            end else begin
                $display("cyc=%0d %s led_4=%b Q=%b ok", pcyc, e.name, led_4, Q);
            end
        end
    end

    function automatic logic [2:0] led_exp();
        if (LOCKOUT && fails >= 3)
            return 3'b101;
        return 3'((1 << digs.size()) - 1);
    endfunction

    task automatic push(input int tag, input logic [2:0] led, input logic q, input string nm);
        exp_t e;
        e.tag  = tag;
        e.led  = led;
        e.q    = q;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic [2:0] eled, input logic eq);
        checks++;
        if (led_4 !== eled || Q !== eq) begin
            errors++;
            $display("FAIL %s: led_4=%b Q=%b expected led_4=%b Q=%b", nm, led_4, Q, eled, eq);
        end else begin
            $display("%s led_4=%b Q=%b ok", nm, led_4, Q);
        end
    endtask

    // Called right after the edge that samples a fresh press.
    task automatic model_press(input int d, input string nm);
        bit ok;
        int tgt;
        if ((LOCKOUT && fails >= 3) || d == 3) begin
            push(pcyc, led_exp(), mq, nm);
            return;
        end
        digs.push_back(d);
        if (digs.size() < PL) begin
            push(pcyc, led_exp(), mq, nm);
            return;
        end
        if (mode) begin
            for (int i = 0; i < PL; i++) upw[i] = digs[i];
        end else begin
            ok = 1'b1;
            for (int i = 0; i < PL; i++) begin
                tgt = mode_def ? defpw[i] : upw[i];
                if (digs[i] != tgt) ok = 1'b0;
            end
            mq = ok;
            if (ok) fails = 0;
            else if (fails < 3) fails++;
        end
        push(pcyc, led_exp(), mq, nm);
        digs.delete();
        push(pcyc + 1, led_exp(), mq, nm);
    endtask

    task automatic press(input int d, input string nm);
        enter    = 1'b1;
        mod3_btn = 2'(d);
        @(posedge clk); #2;
        model_press(d, nm);
        enter = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
    endtask

    task automatic press3(input int a, input int b, input int c, input string nm);
        press(a, nm);
        press(b, nm);
        press(c, nm);
    endtask

    task automatic hold_enter(input int d, input int n);
        enter    = 1'b1;
        mod3_btn = 2'(d);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            if (i == 0) model_press(d, "hold_first");
            else push(pcyc, led_exp(), mq, "hold_repeat");
        end
        enter = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic do_lock_rst();
        lock_rst = 1'b1;
        @(posedge clk); #2;
        lock_rst = 1'b0;
        digs.delete();
        mq = 1'b0;
        push(pcyc, led_exp(), 1'b0, "lock_rst");
        @(posedge clk); #2;
    endtask

    task automatic async_reset();
        #1 rst_all = 1'b1;
        #1;
        digs.delete();
        mq    = 1'b0;
        fails = 0;
        for (int i = 0; i < PL; i++) upw[i] = defpw[i];
        check_now("async_rst", 3'b000, 1'b0);
        rst_all = 1'b0;
        @(posedge clk); #2;
        push(pcyc, 3'b000, 1'b0, "after_rst");
        @(posedge clk); #2;
    endtask

    initial begin
        int r;
        rst_all  = 1'b1;
        enter    = 1'b0;
        mode     = 1'b0;
        mode_def = 1'b0;
        mod3_btn = 2'd0;
        lock_rst = 1'b0;
        mq       = 1'b0;
        fails    = 0;
        for (int i = 0; i < PL; i++) upw[i] = defpw[i];
        #3;
        check_now("reset", 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_all = 1'b0;
        @(posedge clk); #2;

        // Default password checks
        mode = 1'b0; mode_def = 1'b1;
        press3(2, 1, 2, "def_ok");
        press3(2, 2, 2, "def_bad");
        press3(2, 1, 2, "def_ok2");
        do_lock_rst();

        // Asynchronous reset while two digits are in and Q is high
        press3(2, 1, 2, "def_ok3");
        press(2, "partial");
        press(1, "partial");
        async_reset();

        // Program then check the user password
        mode = 1'b1;
        press3(1, 0, 1, "prog");
        mode = 1'b0; mode_def = 1'b0;
        press3(1, 0, 1, "user_ok");
        press3(2, 1, 2, "user_bad");

        // Held enter and invalid digit
        hold_enter(1, 5);
        press(3, "invalid");
        press(0, "after_invalid");
        do_lock_rst();

        // Three wrong checks (lockout when enabled), then relock and full reset
        mode = 1'b0; mode_def = 1'b1;
        press3(0, 0, 0, "bad1");
        press3(1, 1, 1, "bad2");
        press3(0, 1, 2, "bad3");
        press(2, "post_bad");
        do_lock_rst();
        press(1, "post_lock_rst");
        async_reset();
        press3(2, 1, 2, "def_after_rst");

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(9, 0);
            if (r == 0) begin
                do_lock_rst();
            end else if (r == 1) begin
                mode = 1'b0; mode_def = 1'b1;
                press3(2, 1, 2, "rand_def");
            end else begin
                mode     = ($urandom_range(3, 0) == 0);
                mode_def = 1'($urandom_range(1, 0));
                press($urandom_range(3, 0), "rand");
            end
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
